// File: rtl/bike_add_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : bike_add_arbiter
// Function : Round-robin issue of add operations from N_REQ requesters into
//            one shared registered 48-bit adder, with a single response slot.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bike_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*48-1:0]   req_a,
  input  logic [N_REQ*48-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [47:0]           rsp_data,
  output logic                  add_enable,
  output logic                  add_resetn,
  output logic [47:0]           add_din_a,
  output logic [47:0]           add_din_b,
  input  logic [47:0]           add_dout
);

  localparam int c_DATA_W = 48;

  logic [ID_W-1:0] r_ptr;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;

  logic            w_issue_ok;
  logic            w_found;
  logic [ID_W-1:0] w_grant;
  logic [ID_W:0]   w_cand;
  logic            w_xfer;
  logic            w_drain;

  // The output slot can take a new result if it is empty or emptying now.
  assign w_issue_ok = !r_rsp_valid || rsp_ready;
  assign w_drain    = r_rsp_valid && rsp_ready;

  // Search from r_ptr upward, modulo N_REQ; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(N_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(N_REQ);
      end
      if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_xfer = w_found && w_issue_ok && !reset;

  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign add_din_a  = w_xfer ? req_a[w_grant*c_DATA_W +: c_DATA_W] : '0;
  assign add_din_b  = w_xfer ? req_b[w_grant*c_DATA_W +: c_DATA_W] : '0;
  // Holding the clock enable low freezes PREG, which keeps rsp_data stable.
  assign add_enable = !reset && (w_xfer || w_drain);
  assign add_resetn = ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant;
      r_ptr       <= (w_grant == ID_W'(N_REQ-1)) ? '0 : w_grant + ID_W'(1);
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = add_dout;

endmodule

`default_nettype wire

// File: tb/tb_bike_add_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : tb_bike_add_arbiter
// Function : Self-checking bench for bike_add_arbiter with an adder model
//            and an in-order result scoreboard.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bike_add_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*48-1:0]   req_a;
  logic [N*48-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [47:0]       rsp_data;
  logic              add_enable;
  logic              add_resetn;
  logic [47:0]       add_din_a;
  logic [47:0]       add_din_b;
  logic [47:0]       add_dout;

  logic [47:0]       op_a [N];
  logic [47:0]       op_b [N];
  logic [47:0]       p_reg;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [47:0]    sum;
  } exp_t;

  exp_t        sb_q [$];
  logic [N-1:0] last_grant = '0;
  logic        prev_stall = 1'b0;
  logic [IDW-1:0] prev_id;
  logic [47:0] prev_data;

  always #5 clk = ~clk;

  bike_add_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .add_enable (add_enable),
    .add_resetn (add_resetn),
    .add_din_a  (add_din_a),
    .add_din_b  (add_din_b),
    .add_dout   (add_dout)
  );

  // DSP adder model: one register stage with clock enable and sync resetn.
  always @(posedge clk) begin
    if (!add_resetn)     p_reg <= '0;
    else if (add_enable) p_reg <= add_din_a + add_din_b;
  end
  assign add_dout = p_reg;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*48 +: 48] = op_a[i];
      req_b[i*48 +: 48] = op_b[i];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [47:0] s;
    if (reset) begin
      sb_q.delete();
      prev_stall = 1'b0;
      last_grant = '0;
    end else begin
      check_val("onehot_ready", 64'($onehot0(req_ready)), 64'd1);
      if (prev_stall) begin
        check_val("hold_id", 64'(rsp_id), 64'(prev_id));
        check_val("hold_data", 64'(rsp_data), 64'(prev_data));
      end
      if (rsp_valid && !rsp_ready) begin
        check_val("stall_ready", 64'(req_ready), 64'd0);
        check_val("stall_enable", 64'(add_enable), 64'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_val("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("sb_id", 64'(rsp_id), 64'(e.id));
          check_val("sb_data", 64'(rsp_data), 64'(e.sum));
        end
      end
      last_grant = req_valid & req_ready;
      for (int g = 0; g < N; g++) begin
        if (last_grant[g]) begin
          s = op_a[g] + op_b[g];
          sb_q.push_back({IDW'(g), s});
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_id    = rsp_id;
      prev_data  = rsp_data;
    end
  end

  // Advance one cycle; requesters whose operation was accepted load new operands.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_grant[i]) begin
        op_a[i] = {16'($urandom), 32'($urandom)};
        op_b[i] = {16'($urandom), 32'($urandom)};
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] ea;
    int          n;
    logic        got1;

    reset     = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 48'(i + 1);
      op_b[i] = 48'(i + 10);
    end
    tick();
    tick();
    @(negedge clk);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_add_enable", 64'(add_enable), 64'd0);
    check_val("rst_add_resetn", 64'(add_resetn), 64'd0);
    check_val("rst_din_a", 64'(add_din_a), 64'd0);
    check_val("rst_rsp_data", 64'(rsp_data), 64'd0);
    tick();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;

    // Single operation from requester 2
    op_a[2] = 48'h1234;
    op_b[2] = 48'h0001;
    req_valid = 4'b0100;
    @(negedge clk);
    check_val("single_ready", 64'(req_ready), 64'b0100);
    check_val("single_din_a", 64'(add_din_a), 64'h1234);
    check_val("single_din_b", 64'(add_din_b), 64'h1);
    check_val("single_enable", 64'(add_enable), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check_val("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check_val("single_rsp_id", 64'(rsp_id), 64'd2);
    check_val("single_rsp_data", 64'(rsp_data), 64'h1235);
    tick();

    // All four requesters continuously from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = {16'($urandom), 32'($urandom)};
      op_b[i] = {16'($urandom), 32'($urandom)};
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) check_val($sformatf("rr_rsp_valid%0d", k), 64'(rsp_valid), 64'd1);
      tick();
    end
    req_valid = '0;
    tick();

    // Backpressure with requesters 0 and 1
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    @(negedge clk);
    check_val("bp_first_grant", 64'(req_ready), 64'b0001);
    ea = op_a[0] + op_b[0];
    tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check_val("bp_rsp_id", 64'(rsp_id), 64'd0);
      check_val("bp_rsp_data", 64'(rsp_data), 64'(ea));
      check_val("bp_no_ready", 64'(req_ready), 64'd0);
      check_val("bp_enable_low", 64'(add_enable), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val("bp_regrant", 64'(req_ready), 64'b0010);
    check_val("bp_enable_high", 64'(add_enable), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check_val("bp_next_id", 64'(rsp_id), 64'd1);
    tick();

    // Modulo-2^48 wrap-around
    op_a[0] = 48'hFFFF_FFFF_FFFF;
    op_b[0] = 48'h1;
    req_valid = 4'b0001;
    @(negedge clk);
    tick();
    op_a[0] = 48'h8000_0000_0000;
    op_b[0] = 48'h8000_0000_0000;
    @(negedge clk);
    check_val("wrap1_data", 64'(rsp_data), 64'd0);
    check_val("wrap1_valid", 64'(rsp_valid), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check_val("wrap2_data", 64'(rsp_data), 64'd0);
    tick();

    // Fairness: requester 3 continuous, requester 1 pulsed
    req_valid = 4'b1000;
    for (int p = 0; p < 3; p++) begin
      repeat (p + 1) tick();
      req_valid[1] = 1'b1;
      n    = 0;
      got1 = 1'b0;
      for (int c = 0; c < 10 && !got1; c++) begin
        @(negedge clk);
        if (req_ready != '0) n++;
        if (req_ready[1]) got1 = 1'b1;
        tick();
      end
      req_valid[1] = 1'b0;
      check_val("fair_granted", 64'(got1), 64'd1);
      check_val("fair_within2", 64'(n <= 2), 64'd1);
    end
    req_valid = '0;
    tick();

    // Reset while a result is stalled; pointer moved away from zero first
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    tick();
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);
    check_val("mid_pre_valid", 64'(rsp_valid), 64'd1);
    tick();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    check_val("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("mid_rsp_data", 64'(rsp_data), 64'd0);
    check_val("mid_first_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
